// File: rtl/vector_alu_pkg.sv
// Shared opcode encoding for the vector ALU and its lanes.
package vector_alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ZERO = 3'b000,
    OP_XOR  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_INC  = 3'b111
  } alu_op_t;

endpackage

// File: rtl/vector_alu_if.sv
// Valid/ready operand and result bundle between operand fetch and writeback.
interface vector_alu_if
  import vector_alu_pkg::*;
#(
  parameter int dataSize  = 8,
  parameter int laneCount = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [ALU_OP_W-1:0]           operation_select;
  logic                          saturate;
  logic [laneCount-1:0]          lane_mask;
  logic [laneCount*dataSize-1:0] operand1;
  logic [laneCount*dataSize-1:0] operand2;
  logic                          out_valid;
  logic                          out_ready;
  logic [laneCount*dataSize-1:0] result;
  logic [laneCount-1:0]          neg_flags;
  logic [laneCount-1:0]          zero_flags;
  logic                          all_zero;

  modport master (
    output in_valid, operation_select, saturate, lane_mask, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, neg_flags, zero_flags, all_zero
  );

  modport slave (
    input  in_valid, operation_select, saturate, lane_mask, operand1, operand2, out_ready,
    output in_ready, out_valid, result, neg_flags, zero_flags, all_zero
  );
endinterface

// File: rtl/alu_lane.sv
// One combinational ALU lane: operation, optional signed saturation, mask passthrough, flags.
module alu_lane
  import vector_alu_pkg::*;
#(
  parameter int dataSize = 8
) (
  input  alu_op_t               op,
  input  logic                  sat,
  input  logic                  en,
  input  logic [dataSize-1:0]   a,
  input  logic [dataSize-1:0]   b,
  output logic [dataSize-1:0]   res,
  output logic                  neg,
  output logic                  zero
);
  localparam int W = dataSize;
  localparam logic [W-1:0]      SHIFT_LIM = W'(W);
  localparam logic signed [W:0] ONE_EXT   = (W+1)'(1);

  // The sign-extended sum carries one guard bit; a disagreement with the top
  // result bit marks signed overflow and the guard bit gives its direction.
  function automatic logic [W-1:0] sat_fit(input logic signed [W:0] s, input logic sat_en);
    if (sat_en && (s[W] != s[W-1]))
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic [W-1:0]      op_res;

  always_comb begin
    a_ext  = signed'({a[W-1], a});
    b_ext  = signed'({b[W-1], b});
    op_res = '0;
    case (op)
      OP_ZERO: op_res = '0;
      OP_XOR:  op_res = a ^ b;
      OP_ADD:  op_res = sat_fit(a_ext + b_ext, sat);
      OP_SUB:  op_res = sat_fit(a_ext - b_ext, sat);
      OP_MUL:  op_res = a * b;
      OP_SHR:  op_res = (b >= SHIFT_LIM) ? '0 : (a >> b);
      OP_SHL:  op_res = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_INC:  op_res = sat_fit(a_ext + ONE_EXT, sat);
      default: op_res = '0;
    endcase
    res  = en ? op_res : a;
    zero = en && (op_res == '0);
    neg  = en && (a[W-1] != op_res[W-1]) && (op_res != '0);
  end
endmodule

// File: rtl/vector_alu.sv
// Two-stage vector ALU: S1 captures the accepted operation, S2 holds lane results and flags.
module vector_alu
  import vector_alu_pkg::*;
#(
  parameter int dataSize  = 8,
  parameter int laneCount = 4
) (
  input  logic        clk,
  input  logic        rst,
  vector_alu_if.slave bus
);
  localparam int VW = laneCount * dataSize;

  logic                 adv;
  logic                 vld_p1_q, vld_p1_d;
  alu_op_t              op_p1_q, op_p1_d;
  logic                 sat_p1_q, sat_p1_d;
  logic [laneCount-1:0] mask_p1_q, mask_p1_d;
  logic [VW-1:0]        op1_p1_q, op1_p1_d;
  logic [VW-1:0]        op2_p1_q, op2_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic [VW-1:0]        res_p2_q, res_p2_d;
  logic [laneCount-1:0] neg_p2_q, neg_p2_d;
  logic [laneCount-1:0] zero_p2_q, zero_p2_d;
  logic                 allz_p2_q, allz_p2_d;

  logic [VW-1:0]        lane_res;
  logic [laneCount-1:0] lane_neg;
  logic [laneCount-1:0] lane_zero;
  logic                 lane_allz;

  // ---- S1 -> S2 compute ----
  for (genvar i = 0; i < laneCount; i++) begin : g_lane
    alu_lane #(.dataSize(dataSize)) u_lane (
      .op   (op_p1_q),
      .sat  (sat_p1_q),
      .en   (mask_p1_q[i]),
      .a    (op1_p1_q[i*dataSize +: dataSize]),
      .b    (op2_p1_q[i*dataSize +: dataSize]),
      .res  (lane_res[i*dataSize +: dataSize]),
      .neg  (lane_neg[i]),
      .zero (lane_zero[i])
    );
  end

  // Masked lanes count as "zero" for the AND; an all-masked vector reports 0.
  assign lane_allz = (|mask_p1_q) && (&(lane_zero | ~mask_p1_q));

  assign adv          = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    op_p1_d   = op_p1_q;
    sat_p1_d  = sat_p1_q;
    mask_p1_d = mask_p1_q;
    op1_p1_d  = op1_p1_q;
    op2_p1_d  = op2_p1_q;
    vld_p2_d  = vld_p2_q;
    res_p2_d  = res_p2_q;
    neg_p2_d  = neg_p2_q;
    zero_p2_d = zero_p2_q;
    allz_p2_d = allz_p2_q;
    if (adv) begin
      vld_p1_d = bus.in_valid;
      if (bus.in_valid) begin
        op_p1_d   = alu_op_t'(bus.operation_select);
        sat_p1_d  = bus.saturate;
        mask_p1_d = bus.lane_mask;
        op1_p1_d  = bus.operand1;
        op2_p1_d  = bus.operand2;
      end
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        res_p2_d  = lane_res;
        neg_p2_d  = lane_neg;
        zero_p2_d = lane_zero;
        allz_p2_d = lane_allz;
      end
    end
  end

  // ---- input -> S1 ----
  always_ff @(posedge clk) begin
    op_p1_q   <= op_p1_d;
    sat_p1_q  <= sat_p1_d;
    mask_p1_q <= mask_p1_d;
    op1_p1_q  <= op1_p1_d;
    op2_p1_q  <= op2_p1_d;
  end

  // ---- valids and S2 outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      res_p2_q  <= '0;
      neg_p2_q  <= '0;
      zero_p2_q <= '0;
      allz_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      res_p2_q  <= res_p2_d;
      neg_p2_q  <= neg_p2_d;
      zero_p2_q <= zero_p2_d;
      allz_p2_q <= allz_p2_d;
    end
  end

  assign bus.out_valid  = vld_p2_q;
  assign bus.result     = res_p2_q;
  assign bus.neg_flags  = neg_p2_q;
  assign bus.zero_flags = zero_p2_q;
  assign bus.all_zero   = allz_p2_q;
endmodule

// File: tb/tb_vector_alu.sv
// Scoreboard bench for vector_alu (dataSize=8, laneCount=4) with directed, hand-computed vectors.
module tb_vector_alu;
  import vector_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_alu_if #(.dataSize(8), .laneCount(4)) bus ();
  vector_alu #(.dataSize(8), .laneCount(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  neg;
    logic [3:0]  zero;
    logic        az;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_start = 0;
  int   first_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h expected no output", bus.result);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result",     bus.result,             mon_e.res);
        chk("neg_flags",  32'(bus.neg_flags),     32'(mon_e.neg));
        chk("zero_flags", 32'(bus.zero_flags),    32'(mon_e.zero));
        chk("all_zero",   32'(bus.all_zero),      32'(mon_e.az));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic issue(input logic [2:0] op, input logic sat, input logic [3:0] mask,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic [3:0] en, input logic [3:0] ez, input logic eaz);
    int   tries;
    exp_t e;
    last_start           = cyc;
    bus.in_valid         = 1'b1;
    bus.operation_select = op;
    bus.saturate         = sat;
    bus.lane_mask        = mask;
    bus.operand1         = a;
    bus.operand2         = b;
    tries = 0;
    @(negedge clk);
    while (!bus.in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready %b expected 1", bus.in_ready);
    end else begin
      e.res = er; e.neg = en; e.zero = ez; e.az = eaz;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: pending %0d expected 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] held;
  logic [7:0]  v;

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.operation_select = '0;
    bus.saturate = 1'b0;
    bus.lane_mask = '0;
    bus.operand1 = '0;
    bus.operand2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_result",     bus.result,          32'd0);
    chk("rst_neg_flags",  32'(bus.neg_flags),  32'd0);
    chk("rst_zero_flags", 32'(bus.zero_flags), 32'd0);
    chk("rst_all_zero",   32'(bus.all_zero),   32'd0);
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);

    // add / sub / inc with and without saturation
    issue(3'b010, 1'b0, 4'hF, 32'h10FF007F, 32'h20010001, 32'h30000080, 4'b0001, 4'b0110, 1'b0);
    issue(3'b010, 1'b1, 4'hF, 32'h10FF007F, 32'h20010001, 32'h3000007F, 4'b0000, 4'b0110, 1'b0);
    issue(3'b011, 1'b1, 4'hF, 32'h7F058080, 32'hFF057F01, 32'h7F008080, 4'b0000, 4'b0100, 1'b0);
    issue(3'b111, 1'b1, 4'hF, 32'h7FFF0080, 32'h12345678, 32'h7F000181, 4'b0000, 4'b0100, 1'b0);
    issue(3'b111, 1'b0, 4'hF, 32'h7FFF0080, 32'h12345678, 32'h80000181, 4'b1000, 4'b0100, 1'b0);
    // zero reduction and full masking
    issue(3'b011, 1'b0, 4'hF, 32'h05050505, 32'h05050505, 32'h00000000, 4'b0000, 4'b1111, 1'b1);
    issue(3'b011, 1'b0, 4'h0, 32'h05050505, 32'h05050505, 32'h05050505, 4'b0000, 4'b0000, 1'b0);
    // shifts, multiply, zero opcode
    issue(3'b101, 1'b0, 4'hF, 32'h80808080, 32'h09080701, 32'h00000140, 4'b0011, 4'b1100, 1'b0);
    issue(3'b110, 1'b0, 4'hF, 32'h0101FF01, 32'h070004FF, 32'h8001F000, 4'b1000, 4'b0001, 1'b0);
    issue(3'b100, 1'b0, 4'hF, 32'h0F10FF03, 32'h1110FF05, 32'hFF00010F, 4'b1010, 4'b0100, 1'b0);
    issue(3'b000, 1'b1, 4'hF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0000, 4'b1111, 1'b1);
    issue(3'b000, 1'b0, 4'h6, 32'h12345678, 32'h9ABCDEF0, 32'h12000078, 4'b0000, 4'b0110, 1'b1);
    // partial mask on xor
    issue(3'b001, 1'b0, 4'h5, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'hAA55AA55, 4'b0101, 4'b0000, 1'b0);
    drain();

    // back-to-back stream with a 3-cycle downstream stall
    fork
      begin
        for (int k = 1; k <= 5; k++) begin
          v = 8'(k * 17);
          issue(3'b010, 1'b0, 4'hF, {4{v}}, 32'h01010101, {4{v + 8'd1}}, 4'b0000, 4'b0000, 1'b0);
          if (k == 1) first_start = last_start;
        end
      end
      begin
        int t = 0;
        @(posedge clk);
        #1;
        while (!bus.out_valid && t < 20) begin
          @(posedge clk);
          #1;
          t++;
        end
        // edges from presenting the first operation to out_valid
        chk("latency", 32'(cyc - first_start), 32'd2);
        bus.out_ready = 1'b0;
        held = bus.result;
        #1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_result",    bus.result,         held);
          chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with two operations in flight, handshake offered during reset
    issue(3'b010, 1'b0, 4'hF, 32'h11111111, 32'h22222222, 32'h33333333, 4'b0000, 4'b0000, 1'b0);
    issue(3'b010, 1'b0, 4'hF, 32'h01010101, 32'h01010101, 32'h02020202, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.operation_select = 3'b111;
    bus.operand1 = 32'h40404040;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb_q.delete();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_result",    bus.result,         32'd0);
    chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_no_ghost", 32'(bus.out_valid), 32'd0);
    issue(3'b010, 1'b0, 4'hF, 32'h01010101, 32'h02020202, 32'h03030303, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    chk("post_rst_latency", 32'(cyc - last_start), 32'd2);
    chk("post_rst_valid",   32'(bus.out_valid),    32'd1);
    drain();

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
